simd_accum_dsp: RTL and testbench

- Lane-parametrised SIMD accumulator for the DSP datapath; the next generation of the fixed two-lane 24-bit add block.
- Splits a 48-bit word into 1, 2 or 4 independent lanes and sums ACC_LEN valid samples per lane. Emits one result word per frame.
- Adds per-lane signed/unsigned overflow detection, optional saturation, frame clear and a valid-pulse output.
- Sits after channelisers/decimators ahead of power/statistics logic; written behaviourally so synthesis maps each lane set onto one DSP48E2 in ONE48/TWO24/FOUR12 SIMD mode.

---
 rtl/simd_accum_dsp.sv | 126 ++++++++++++
 tb/tb_simd_accum_dsp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_accum_dsp.sv
// SIMD frame accumulator: a 48-bit word is split into NLANE independent lanes.
// Each lane sums ACC_LEN valid samples and reports overflow, with optional saturation.
module simd_accum_dsp #(
  parameter int unsigned NLANE    = 2,
  parameter int unsigned ACC_LEN  = 4,
  parameter bit          SIGNED   = 1'b1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  logic [47:0]      in_data_i,
  output logic             out_valid_o,
  output logic [47:0]      out_data_o,
  output logic [NLANE-1:0] ovf_o,
  output logic             busy_o
);

  localparam int unsigned LW = 48 / NLANE;
  localparam int unsigned CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  if (!(NLANE == 1 || NLANE == 2 || NLANE == 4)) begin : g_bad_nlane
    $error("simd_accum_dsp: NLANE must be 1, 2 or 4");
  end
  if (ACC_LEN < 1) begin : g_bad_acc_len
    $error("simd_accum_dsp: ACC_LEN must be >= 1");
  end

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [47:0]      acc_q, acc_d;
  logic [NLANE-1:0] sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;
  logic [47:0]      out_data_q, out_data_d;
  logic [NLANE-1:0] ovf_q, ovf_d;

  logic [47:0]      sum_sat;
  logic [NLANE-1:0] lane_ovf;
  logic             first;
  logic             last;

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == LAST);

  // The first sample of a frame adds to zero, so load and accumulate share one adder.
  always_comb begin
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic [LW:0]   s;
    sum_sat  = '0;
    lane_ovf = '0;
    a        = '0;
    b        = '0;
    s        = '0;
    for (int unsigned k = 0; k < NLANE; k++) begin
      a = first ? '0 : acc_q[k*LW +: LW];
      b = in_data_i[k*LW +: LW];
      s = {1'b0, a} + {1'b0, b};
      if (SIGNED) begin
        lane_ovf[k] = (a[LW-1] == b[LW-1]) && (s[LW-1] != a[LW-1]);
      end else begin
        lane_ovf[k] = s[LW];
      end
      if (SATURATE && lane_ovf[k]) begin
        if (SIGNED && a[LW-1]) begin
          sum_sat[k*LW +: LW] = {1'b1, {(LW-1){1'b0}}};
        end else if (SIGNED) begin
          sum_sat[k*LW +: LW] = {1'b0, {(LW-1){1'b1}}};
        end else begin
          sum_sat[k*LW +: LW] = '1;
        end
      end else begin
        sum_sat[k*LW +: LW] = s[LW-1:0];
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    if (clear_i) begin
      cnt_d    = '0;
      sticky_d = '0;
    end else if (in_valid_i) begin
      acc_d    = sum_sat;
      sticky_d = first ? lane_ovf : (sticky_q | lane_ovf);
      if (last) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = sum_sat;
        ovf_d       = sticky_d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (cnt_q != '0);

endmodule

// File: tb/tb_simd_accum_dsp.sv
// Directed bench for simd_accum_dsp: four configurations share one stimulus bus.
module tb_simd_accum_dsp;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic        vld = 1'b0;
  logic [47:0] din = '0;

  // a: 2x24 signed saturating, b: 2x24 signed wrapping,
  // c: 4x12 unsigned ACC_LEN=1, d: 4x12 unsigned ACC_LEN=2
  logic a_v, b_v, c_v, d_v;
  logic a_b, b_b, c_b, d_b;
  logic [47:0] a_d, b_d, c_d, d_d;
  logic [1:0] a_o, b_o;
  logic [3:0] c_o, d_o;

  int pass = 0;
  int total = 0;
  int na = 0, nb = 0, nc = 0, nd = 0;

  always #5 clk = ~clk;

  simd_accum_dsp #(.NLANE(2), .ACC_LEN(4), .SIGNED(1'b1), .SATURATE(1'b1)) u_a (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clr), .in_valid_i(vld), .in_data_i(din),
    .out_valid_o(a_v), .out_data_o(a_d), .ovf_o(a_o), .busy_o(a_b));
  simd_accum_dsp #(.NLANE(2), .ACC_LEN(4), .SIGNED(1'b1), .SATURATE(1'b0)) u_b (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clr), .in_valid_i(vld), .in_data_i(din),
    .out_valid_o(b_v), .out_data_o(b_d), .ovf_o(b_o), .busy_o(b_b));
  simd_accum_dsp #(.NLANE(4), .ACC_LEN(1), .SIGNED(1'b0), .SATURATE(1'b0)) u_c (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clr), .in_valid_i(vld), .in_data_i(din),
    .out_valid_o(c_v), .out_data_o(c_d), .ovf_o(c_o), .busy_o(c_b));
  simd_accum_dsp #(.NLANE(4), .ACC_LEN(2), .SIGNED(1'b0), .SATURATE(1'b0)) u_d (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clr), .in_valid_i(vld), .in_data_i(din),
    .out_valid_o(d_v), .out_data_o(d_d), .ovf_o(d_o), .busy_o(d_b));

  always @(negedge clk) begin
    if (a_v) na++;
    if (b_v) nb++;
    if (c_v) nc++;
    if (d_v) nd++;
  end

  // Drive one cycle of inputs at the negedge; return #1 after the capturing posedge.
  task automatic step(input logic v, input logic c, input logic [47:0] d);
    @(negedge clk);
    vld = v;
    clr = c;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic abort_frame();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    vld  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      @(posedge clk);
      #1;
    end
    total++;
    if ({a_v, b_v, c_v, d_v} !== 4'b0000)
      $display("FAIL reset_valid: got %b expected 0000", {a_v, b_v, c_v, d_v});
    else pass++;
    total++;
    if ((a_d | b_d | c_d | d_d) !== 48'h0)
      $display("FAIL reset_data: got %h expected 0", a_d | b_d | c_d | d_d);
    else pass++;
    total++;
    if ({a_o, b_o, c_o, d_o} !== 12'h0 || {a_b, b_b, c_b, d_b} !== 4'b0000)
      $display("FAIL reset_ovf_busy: got ovf %h busy %b expected 0/0",
               {a_o, b_o, c_o, d_o}, {a_b, b_b, c_b, d_b});
    else pass++;
    @(negedge clk);
    rstn = 1'b1;
    din  = 48'h000001_000001;
    @(posedge clk);
    #1;
    total++;
    if (a_b !== 1'b1)
      $display("FAIL reset_release_busy: got %b expected 1", a_b);
    else pass++;
    abort_frame();
  endtask

  task automatic test_basic_sum();
    int na0;
    abort_frame();
    na0 = na;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, {24'hFFFFFF, 24'(i)});
      step(1'b0, 1'b0, '0);
    end
    total++;
    if (na != na0 || a_b !== 1'b1)
      $display("FAIL basic_early: got strobes %0d busy %b expected 0 1", na - na0, a_b);
    else pass++;
    step(1'b1, 1'b0, {24'hFFFFFF, 24'd4});
    total++;
    if (a_v !== 1'b1 || a_d !== 48'hFFFFFC_00000A || a_o !== 2'b00)
      $display("FAIL basic_sum_sat: got v=%b %h ovf %b expected 1 fffffc00000a 00", a_v, a_d, a_o);
    else pass++;
    total++;
    if (b_v !== 1'b1 || b_d !== 48'hFFFFFC_00000A || b_o !== 2'b00)
      $display("FAIL basic_sum_wrap: got v=%b %h ovf %b expected 1 fffffc00000a 00", b_v, b_d, b_o);
    else pass++;
    step(1'b0, 1'b0, '0);
    total++;
    if (a_v !== 1'b0 || a_d !== 48'hFFFFFC_00000A || a_b !== 1'b0)
      $display("FAIL basic_hold: got v=%b %h busy %b expected 0 fffffc00000a 0", a_v, a_d, a_b);
    else pass++;
  endtask

  task automatic test_overflow();
    logic [47:0] v3 [4];
    abort_frame();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 48'h000000_400000);
    total++;
    if (a_d !== 48'h000000_7FFFFF || a_o !== 2'b01)
      $display("FAIL ovf_pos_sat: got %h ovf %b expected 0000007fffff 01", a_d, a_o);
    else pass++;
    total++;
    if (b_d !== 48'h000000_000000 || b_o !== 2'b01)
      $display("FAIL ovf_pos_wrap: got %h ovf %b expected 000000000000 01", b_d, b_o);
    else pass++;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 48'h000001_000001);
    total++;
    if (a_d !== 48'h000004_000004 || a_o !== 2'b00 || b_o !== 2'b00)
      $display("FAIL ovf_clear_next: got %h ovf %b/%b expected 000004000004 00/00", a_d, a_o, b_o);
    else pass++;
    step(1'b1, 1'b0, 48'hA00000_000000);
    step(1'b1, 1'b0, 48'hA00000_000000);
    step(1'b1, 1'b0, 48'h0);
    step(1'b1, 1'b0, 48'h0);
    total++;
    if (a_d !== 48'h800000_000000 || a_o !== 2'b10)
      $display("FAIL ovf_neg_sat: got %h ovf %b expected 800000000000 10", a_d, a_o);
    else pass++;
    total++;
    if (b_d !== 48'h400000_000000 || b_o !== 2'b10)
      $display("FAIL ovf_neg_wrap: got %h ovf %b expected 400000000000 10", b_d, b_o);
    else pass++;
    v3[0] = 48'h000000_600000;
    v3[1] = 48'h000000_600000;
    v3[2] = 48'h000000_800001;
    v3[3] = 48'h000000_000005;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, v3[i]);
    total++;
    if (a_d !== 48'h000000_000005 || a_o !== 2'b01)
      $display("FAIL ovf_from_clamp_sat: got %h ovf %b expected 000000000005 01", a_d, a_o);
    else pass++;
    total++;
    if (b_d !== 48'h000000_400006 || b_o !== 2'b01)
      $display("FAIL ovf_from_clamp_wrap: got %h ovf %b expected 000000400006 01", b_d, b_o);
    else pass++;
  endtask

  task automatic test_lanes();
    int nc0;
    abort_frame();
    step(1'b1, 1'b0, 48'h000_000_001_FFF);
    total++;
    if (c_v !== 1'b1 || c_d !== 48'h000_000_001_FFF || c_o !== 4'b0000)
      $display("FAIL lanes_single: got v=%b %h ovf %b expected 1 000000001fff 0000", c_v, c_d, c_o);
    else pass++;
    nc0 = nc;
    step(1'b1, 1'b0, 48'h123_456_789_ABC);
    total++;
    if (c_v !== 1'b1 || c_d !== 48'h123_456_789_ABC || nc != nc0 + 1)
      $display("FAIL lanes_back_to_back: got v=%b %h strobes %0d expected 1 123456789abc 1",
               c_v, c_d, nc - nc0);
    else pass++;
    abort_frame();
    step(1'b1, 1'b0, 48'h7FF_800_000_FFF);
    step(1'b1, 1'b0, 48'h001_800_000_001);
    total++;
    if (d_v !== 1'b1 || d_d !== 48'h800_000_000_000 || d_o !== 4'b0101)
      $display("FAIL lanes_isolation: got v=%b %h ovf %b expected 1 800000000000 0101", d_v, d_d, d_o);
    else pass++;
  endtask

  task automatic test_clear();
    int na0;
    abort_frame();
    na0 = na;
    step(1'b1, 1'b0, 48'd5);
    step(1'b1, 1'b0, 48'd5);
    step(1'b1, 1'b1, 48'd5);
    total++;
    if (a_b !== 1'b0)
      $display("FAIL clear_busy: got %b expected 0", a_b);
    else pass++;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 48'd1);
    step(1'b0, 1'b1, '0);
    total++;
    if (na != na0 + 1 || a_d !== 48'd4)
      $display("FAIL clear_result: got strobes %0d data %h expected 1 000000000004", na - na0, a_d);
    else pass++;
    step(1'b0, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    abort_frame();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 48'd2);
    @(negedge clk);
    vld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    total++;
    if (b_v !== 1'b0 || b_d !== 48'h0 || b_o !== 2'b00 || b_b !== 1'b0)
      $display("FAIL async_midframe: got v=%b %h ovf %b busy %b expected all 0", b_v, b_d, b_o, b_b);
    else pass++;
    #1 rstn = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 48'd2);
    total++;
    if (b_v !== 1'b1 || b_d !== 48'd8)
      $display("FAIL async_after: got v=%b %h expected 1 000000000008", b_v, b_d);
    else pass++;
    #1 rstn = 1'b0;
    #1;
    total++;
    if (b_v !== 1'b0 || a_v !== 1'b0)
      $display("FAIL async_cancel_strobe: got %b/%b expected 0/0", a_v, b_v);
    else pass++;
    #1 rstn = 1'b1;
    step(1'b0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_overflow();
    test_lanes();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
